// File: rtl/conv3x3_feeder_pkg.sv
// conv3x3_pkg: shared types and constants for the 3x3 convolution feeder.
//   state_e   : feeder FSM states (IDLE, STREAM, WAIT, HOLD)
//   TAPS      : taps per window (fixed 3x3 = 9)
//   TAP_IDX_W : width of the tap index / tap counter
package conv3x3_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    WAIT   = 2'd2,
    HOLD   = 2'd3
  } state_e;

  localparam int TAPS      = 9;
  localparam int TAP_IDX_W = $clog2(TAPS);

endpackage

// File: rtl/conv3x3_feeder_tap_sel.sv
// conv3x3_tap_sel: registered TAPS:1 selector for the activation and weight
// vectors. When i_load is high the tap selected by i_idx is registered onto
// o_x/o_w; otherwise both outputs register zero.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_load              register the selected tap this edge
//   i_idx               tap index to select
//   i_x_vec, i_w_vec    packed tap vectors, tap k at [k*BW +: BW]
//   o_x, o_w            registered selected tap (0 when not loading)
module conv3x3_tap_sel
  import conv3x3_pkg::*;
#(
  parameter int X_BW = 8,
  parameter int W_BW = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [TAP_IDX_W-1:0]     i_idx,
  input  logic [TAPS*X_BW-1:0]     i_x_vec,
  input  logic [TAPS*W_BW-1:0]     i_w_vec,
  output logic signed [X_BW-1:0]   o_x,
  output logic signed [W_BW-1:0]   o_w
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_x <= '0;
      o_w <= '0;
    end else if (i_load) begin
      o_x <= i_x_vec[int'(i_idx)*X_BW +: X_BW];
      o_w <= i_w_vec[int'(i_idx)*W_BW +: W_BW];
    end else begin
      o_x <= '0;
      o_w <= '0;
    end
  end

endmodule

// File: rtl/conv3x3_feeder.sv
// conv3x3_feeder: accepts one 3x3 window (x, w, psum) in a single handshake,
// streams the nine (x, w) taps into the serial convolution MAC one per clock,
// waits CONV_LAT cycles, captures the MAC result and presents it on a
// valid/ready port.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_win_valid / o_win_ready    window handshake (ready only when idle)
//   i_win_x, i_win_w, i_win_psum window activations, weights, partial sum
//   o_x, o_w, o_psum, o_first    MAC drive (zero outside streaming)
//   i_y                          MAC result
//   o_res_valid / i_res_ready    result handshake
//   o_res_y                      captured result
// Build option: define CONV3X3_FEEDER_RELU_EN to clamp negative results to 0.
module conv3x3_feeder
  import conv3x3_pkg::*;
#(
  parameter int X_BW     = 8,
  parameter int W_BW     = 8,
  parameter int I_BW     = 19,
  parameter int O_BW     = 19,
  parameter int TAPS     = conv3x3_pkg::TAPS,
  parameter int CONV_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_win_valid,
  output logic                     o_win_ready,
  input  logic [TAPS*X_BW-1:0]     i_win_x,
  input  logic [TAPS*W_BW-1:0]     i_win_w,
  input  logic signed [I_BW-1:0]   i_win_psum,
  output logic signed [X_BW-1:0]   o_x,
  output logic signed [W_BW-1:0]   o_w,
  output logic signed [I_BW-1:0]   o_psum,
  output logic                     o_first,
  input  logic signed [O_BW-1:0]   i_y,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic signed [O_BW-1:0]   o_res_y
);

  localparam int LAT_W = (CONV_LAT > 1) ? $clog2(CONV_LAT) : 1;

  function automatic logic signed [O_BW-1:0] res_fn(input logic signed [O_BW-1:0] y);
`ifdef CONV3X3_FEEDER_RELU_EN
    return y[O_BW-1] ? '0 : y;
`else
    return y;
`endif
  endfunction

  state_e                 state_q;
  logic [TAP_IDX_W-1:0]   tap_cnt_q;
  logic [LAT_W-1:0]       lat_cnt_q;
  logic [TAPS*X_BW-1:0]   x_q;
  logic [TAPS*W_BW-1:0]   w_q;

  logic                   win_hs;
  logic                   last_tap;
  logic                   last_lat;
  logic                   sel_load_d;
  logic [TAP_IDX_W-1:0]   sel_idx_d;
  logic [TAPS*X_BW-1:0]   sel_x_d;
  logic [TAPS*W_BW-1:0]   sel_w_d;

  // The selector registers the tap for the *next* cycle, so at the window
  // handshake it reads tap 0 straight from the inputs (the capture registers
  // are only loaded on that same edge); afterwards it reads the captured copy.
  always_comb begin
    win_hs     = (state_q == IDLE) && i_win_valid;
    last_tap   = (tap_cnt_q == TAP_IDX_W'(TAPS - 1));
    last_lat   = (lat_cnt_q == LAT_W'(CONV_LAT - 1));
    sel_load_d = 1'b0;
    sel_idx_d  = '0;
    sel_x_d    = x_q;
    sel_w_d    = w_q;
    if (win_hs) begin
      sel_load_d = 1'b1;
      sel_x_d    = i_win_x;
      sel_w_d    = i_win_w;
    end else if ((state_q == STREAM) && !last_tap) begin
      sel_load_d = 1'b1;
      sel_idx_d  = tap_cnt_q + TAP_IDX_W'(1);
    end
  end

  conv3x3_tap_sel #(
    .X_BW (X_BW),
    .W_BW (W_BW)
  ) u_tap_sel (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (sel_load_d),
    .i_idx   (sel_idx_d),
    .i_x_vec (sel_x_d),
    .i_w_vec (sel_w_d),
    .o_x     (o_x),
    .o_w     (o_w)
  );

  // Window data registers: data only, loaded on the handshake.
  always_ff @(posedge i_clk) begin
    if (win_hs) begin
      x_q <= i_win_x;
      w_q <= i_win_w;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      tap_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      o_win_ready <= 1'b1;
      o_first     <= 1'b0;
      o_psum      <= '0;
      o_res_valid <= 1'b0;
      o_res_y     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_hs) begin
            state_q     <= STREAM;
            tap_cnt_q   <= '0;
            o_win_ready <= 1'b0;
            o_first     <= 1'b1;
            o_psum      <= i_win_psum;
          end
        end
        STREAM: begin
          o_first <= 1'b0;
          if (last_tap) begin
            state_q   <= WAIT;
            tap_cnt_q <= '0;
            lat_cnt_q <= '0;
            o_psum    <= '0;
          end else begin
            tap_cnt_q <= tap_cnt_q + TAP_IDX_W'(1);
          end
        end
        WAIT: begin
          if (last_lat) begin
            state_q     <= HOLD;
            lat_cnt_q   <= '0;
            o_res_valid <= 1'b1;
            o_res_y     <= res_fn(i_y);
          end else begin
            lat_cnt_q <= lat_cnt_q + LAT_W'(1);
          end
        end
        HOLD: begin
          if (i_res_ready) begin
            state_q     <= IDLE;
            o_res_valid <= 1'b0;
            o_res_y     <= '0;
            o_win_ready <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_feeder.sv
module tb_conv3x3_feeder;

  localparam int X_BW     = 8;
  localparam int W_BW     = 8;
  localparam int I_BW     = 19;
  localparam int O_BW     = 19;
  localparam int TAPS     = 9;
  localparam int CONV_LAT = 1;
  localparam int N_RAND   = 12;

  logic                    clk;
  logic                    rst;
  logic                    win_valid;
  logic                    win_ready;
  logic [TAPS*X_BW-1:0]    win_x;
  logic [TAPS*W_BW-1:0]    win_w;
  logic signed [I_BW-1:0]  win_psum;
  logic signed [X_BW-1:0]  o_x;
  logic signed [W_BW-1:0]  o_w;
  logic signed [I_BW-1:0]  o_psum;
  logic                    o_first;
  logic signed [O_BW-1:0]  i_y;
  logic                    res_valid;
  logic                    res_ready;
  logic signed [O_BW-1:0]  res_y;

  conv3x3_feeder #(
    .X_BW(X_BW), .W_BW(W_BW), .I_BW(I_BW), .O_BW(O_BW),
    .TAPS(TAPS), .CONV_LAT(CONV_LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_win_valid (win_valid),
    .o_win_ready (win_ready),
    .i_win_x     (win_x),
    .i_win_w     (win_w),
    .i_win_psum  (win_psum),
    .o_x         (o_x),
    .o_w         (o_w),
    .o_psum      (o_psum),
    .o_first     (o_first),
    .i_y         (i_y),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_y     (res_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x[TAPS];
    int w[TAPS];
    int psum;
    int y;      // MAC result the bench model presents for this window
    int rdly;   // cycles of result backpressure
  } vec_t;

  vec_t vecs[$];
  int   n_chk;
  int   n_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected captured result: truncate to O_BW, clamp when ReLU is built in.
  function automatic longint exp_res(input int y);
    logic signed [O_BW-1:0] t;
    t = O_BW'(y);
`ifdef CONV3X3_FEEDER_RELU_EN
    if (t < 0) t = '0;
`endif
    return longint'(t);
  endfunction

  task automatic drive_win(input vec_t v);
    for (int k = 0; k < TAPS; k++) begin
      win_x[k*X_BW +: X_BW] = X_BW'(v.x[k]);
      win_w[k*W_BW +: W_BW] = W_BW'(v.w[k]);
    end
    win_psum = I_BW'(v.psum);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " win_ready"}, longint'(win_ready), 1);
    chk({tag, " o_x"}, longint'(o_x), 0);
    chk({tag, " o_w"}, longint'(o_w), 0);
    chk({tag, " o_psum"}, longint'(o_psum), 0);
    chk({tag, " o_first"}, longint'(o_first), 0);
    chk({tag, " res_valid"}, longint'(res_valid), 0);
    chk({tag, " res_y"}, longint'(res_y), 0);
  endtask

  // One full window: handshake, stream, wait, result with backpressure.
  // During the result hold the next window (if any) is already offered and
  // must not be taken until the result handshake completes.
  task automatic run_window(input int id, input vec_t v, input bit has_next, input vec_t nv);
    string tg;
    drive_win(v);
    win_valid = 1'b1;
    chk($sformatf("w%0d ready before hs", id), longint'(win_ready), 1);
    step();
    win_valid = 1'b0;
    win_x     = {$urandom, $urandom, $urandom};
    win_w     = {$urandom, $urandom, $urandom};
    win_psum  = I_BW'($urandom);
    for (int c = 1; c <= TAPS + CONV_LAT; c++) begin
      tg        = $sformatf("w%0d c%0d", id, c);
      res_ready = 1'($urandom);
      i_y       = O_BW'($urandom);
      if (c <= TAPS) begin
        chk({tg, " o_x"}, longint'(o_x), longint'(v.x[c-1]));
        chk({tg, " o_w"}, longint'(o_w), longint'(v.w[c-1]));
        chk({tg, " o_first"}, longint'(o_first), (c == 1) ? 1 : 0);
        chk({tg, " o_psum"}, longint'(o_psum), longint'(v.psum));
      end else begin
        chk({tg, " o_x idle"}, longint'(o_x), 0);
        chk({tg, " o_w idle"}, longint'(o_w), 0);
        chk({tg, " o_first idle"}, longint'(o_first), 0);
        chk({tg, " o_psum idle"}, longint'(o_psum), 0);
      end
      chk({tg, " win_ready"}, longint'(win_ready), 0);
      chk({tg, " res_valid"}, longint'(res_valid), 0);
      if (c == TAPS + CONV_LAT) i_y = O_BW'(v.y);
      step();
    end
    i_y = O_BW'($urandom);
    if (has_next) begin
      drive_win(nv);
      win_valid = 1'b1;
    end
    for (int d = 0; d <= v.rdly; d++) begin
      tg = $sformatf("w%0d hold%0d", id, d);
      chk({tg, " res_valid"}, longint'(res_valid), 1);
      chk({tg, " res_y"}, longint'(res_y), exp_res(v.y));
      chk({tg, " win_ready"}, longint'(win_ready), 0);
      chk({tg, " o_x"}, longint'(o_x), 0);
      res_ready = (d == v.rdly);
      step();
    end
    res_ready = 1'b0;
    tg = $sformatf("w%0d post", id);
    chk({tg, " res_valid"}, longint'(res_valid), 0);
    chk({tg, " win_ready"}, longint'(win_ready), 1);
  endtask

  initial begin
    vec_t v;
    vec_t none;
    int   s;
    n_chk     = 0;
    n_err     = 0;
    rst       = 1'b1;
    win_valid = 1'b0;
    win_x     = '0;
    win_w     = '0;
    win_psum  = '0;
    i_y       = '0;
    res_ready = 1'b0;

    // Directed windows; expected MAC results worked out by hand.
    vecs.push_back('{'{100, 10, 100, 20, 100, 10, 16, 0, 0},
                     '{50, 5, 15, 50, 50, 40, 5, 0, 0}, 0, 13030, 5});
    vecs.push_back('{'{1, 2, 3, 4, 5, 6, 7, 8, 9},
                     '{1, 1, 1, 1, 1, 1, 1, 1, 1}, -300, -255, 0});
    vecs.push_back('{'{-10, 0, 0, 0, 0, 0, 0, 0, 0},
                     '{120, 0, 0, 0, 0, 0, 0, 0, 0}, 0, -1200, 1});
    vecs.push_back('{'{-128, -128, -128, -128, -128, -128, -128, -128, -128},
                     '{127, 127, 127, 127, 127, 127, 127, 127, 127}, 0, -146304, 0});
    vecs.push_back('{'{127, -1, 0, 5, -77, 33, -128, 1, 64},
                     '{-128, 127, 9, -3, 2, 0, -1, 100, 1}, 262143, 0, 2});

    // Randomized windows; the MAC model is the plain dot product plus psum.
    for (int r = 0; r < N_RAND; r++) begin
      v.psum = int'($urandom_range(200000)) - 100000;
      s = v.psum;
      for (int k = 0; k < TAPS; k++) begin
        v.x[k] = int'($urandom_range(255)) - 128;
        v.w[k] = int'($urandom_range(255)) - 128;
        s += v.x[k] * v.w[k];
      end
      v.y    = s;
      v.rdly = int'($urandom_range(3));
      vecs.push_back(v);
    end
    // Hand-fill the fifth entry's y from the model (psum at its maximum).
    v = vecs[4];
    s = v.psum;
    for (int k = 0; k < TAPS; k++) s += v.x[k] * v.w[k];
    v.y = s;
    vecs[4] = v;
    none = vecs[0];

    step();
    step();
    rst = 1'b0;
    chk_reset("reset");

    // Reset while tap 4 is on the MAC bus.
    drive_win(vecs[0]);
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    for (int c = 2; c <= 5; c++) step();
    chk("midstream o_x tap4", longint'(o_x), 100);
    chk("midstream o_w tap4", longint'(o_w), 50);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("midstream rst");

    for (int i = 0; i < vecs.size(); i++) begin
      if (i + 1 < vecs.size()) run_window(i, vecs[i], 1'b1, vecs[i+1]);
      else                     run_window(i, vecs[i], 1'b0, none);
    end

    win_valid = 1'b0;
    step();
    chk("final win_ready", longint'(win_ready), 1);
    chk("final res_valid", longint'(res_valid), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
